mer_meas_ctrl: RTL and testbench

MER_MEAS_CTRL -- requirements
Module: mer_meas_ctrl

---
 rtl/mer_meas_ctrl.sv | 96 +++++++++
 tb/tb_mer_meas_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mer_meas_ctrl.sv
// mer_meas_ctrl: windowed MER measurement control (|dec_var| mean, error power, symbol error count).
module mer_meas_ctrl #(
    parameter int WIN_LOG2    = 18,
    parameter int SETTLE_SYMS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sym_clk_en,
    input  logic                start,
    input  logic                cont,
    input  logic                abort,
    input  logic [17:0]         dec_var,
    input  logic [17:0]         error,
    input  logic                sym_error,
    output logic                clear_accum,
    output logic                busy,
    output logic                done,
    output logic [17:0]         ref_level,
    output logic [17:0]         err_power,
    output logic [WIN_LOG2:0]   err_count
);
    localparam int SW = $clog2(SETTLE_SYMS + 2);
    localparam int AW = WIN_LOG2 + 18;
    typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, ACCUM, DONE} state_t;
    state_t state, state_nxt;
    logic [1:0] rst_sync;
    logic rst_n;
    logic [17:0] abs_dv, sq_c;
    logic signed [35:0] sq;
    logic [AW-1:0] sum_abs, sum_sq, sum_abs_nxt, sum_sq_nxt;
    logic [WIN_LOG2:0] sym_cnt, err_cnt, err_cnt_nxt;
    logic [SW-1:0] settle_cnt;
    logic last_sym, settle_done;
    // Reset asserts asynchronously but releases two edges later, so IDLE is held across release.
    always_ff @(posedge clk or negedge reset)
        if (!reset) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    assign rst_n = rst_sync[1];
    assign abs_dv = dec_var[17] ? ((dec_var == 18'h20000) ? 18'h1FFFF : -dec_var) : dec_var;
    assign sq = $signed(error) * $signed(error);
    assign sq_c = sq[34:17];
    assign sum_abs_nxt = sum_abs + AW'(abs_dv);
    assign sum_sq_nxt = sum_sq + AW'(sq_c);
    assign err_cnt_nxt = err_cnt + (WIN_LOG2 + 1)'(sym_error);
    assign last_sym = (state == ACCUM) && sym_clk_en && (sym_cnt == {1'b0, {WIN_LOG2{1'b1}}});
    assign settle_done = (SETTLE_SYMS == 0) || (sym_clk_en && settle_cnt == SW'(SETTLE_SYMS - 1));
    assign clear_accum = state == CLEAR;
    assign busy = state != IDLE;
    assign done = state == DONE;
    always_comb begin
        state_nxt = state;
        if (abort) state_nxt = IDLE;
        else
            case (state)
                IDLE:    state_nxt = start ? CLEAR : IDLE;
                CLEAR:   state_nxt = SETTLE;
                SETTLE:  state_nxt = settle_done ? ACCUM : SETTLE;
                ACCUM:   state_nxt = last_sym ? DONE : ACCUM;
                DONE:    state_nxt = cont ? CLEAR : IDLE;
                default: state_nxt = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            sum_abs <= '0;
            sum_sq <= '0;
            sym_cnt <= '0;
            err_cnt <= '0;
            settle_cnt <= '0;
            ref_level <= '0;
            err_power <= '0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                sum_abs <= '0;
                sum_sq <= '0;
                sym_cnt <= '0;
                err_cnt <= '0;
                settle_cnt <= '0;
            end else if (state == SETTLE && sym_clk_en) settle_cnt <= settle_cnt + 1'b1;
            else if (state == ACCUM && sym_clk_en) begin
                sum_abs <= sum_abs_nxt;
                sum_sq <= sum_sq_nxt;
                err_cnt <= err_cnt_nxt;
                sym_cnt <= sym_cnt + 1'b1;
            end
            // Results are captured with the final symbol folded in, so they are valid while done is high.
            if (last_sym && !abort) begin
                ref_level <= sum_abs_nxt[AW-1:WIN_LOG2];
                err_power <= sum_sq_nxt[AW-1:WIN_LOG2];
                err_count <= err_cnt_nxt;
            end
        end
endmodule

// File: tb/tb_mer_meas_ctrl.sv
// tb_mer_meas_ctrl: directed self-checking bench, 4-symbol window, 2 settle symbols, strobe every 4th clk.
module tb_mer_meas_ctrl;
    logic clk = 0, reset = 0, sym_clk_en = 0, start = 0, cont = 0, abort = 0, sym_error = 0;
    logic [17:0] dec_var = 0, error = 0;
    logic clear_accum, busy, done;
    logic [17:0] ref_level, err_power;
    logic [2:0] err_count;
    int checks = 0, errors = 0, n_clr = 0, n_done = 0, clr0 = 0;

    mer_meas_ctrl #(.WIN_LOG2(2), .SETTLE_SYMS(2)) dut (
        .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .start(start), .cont(cont),
        .abort(abort), .dec_var(dec_var), .error(error), .sym_error(sym_error),
        .clear_accum(clear_accum), .busy(busy), .done(done), .ref_level(ref_level),
        .err_power(err_power), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clear_accum) n_clr++;
        if (done) n_done++;
    end

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task sym(input logic [17:0] dv, input logic [17:0] er, input logic se);
        repeat (3) @(negedge clk);
        dec_var = dv;
        error = er;
        sym_error = se;
        sym_clk_en = 1;
        @(negedge clk);
        sym_clk_en = 0;
    endtask

    task go();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task run_win(input logic [17:0] dv, input logic [17:0] er, input logic se, input string tag);
        repeat (5) sym(dv, er, se);
        check({tag, "_early_done"}, done, 0);
        sym(dv, er, se);
        check({tag, "_done"}, done, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_clr", clear_accum, 0);
        check("rst_done", done, 0);
        check("rst_ref", ref_level, 0);
        check("rst_pow", err_power, 0);
        check("rst_cnt", err_count, 0);
        start = 1;
        reset = 1;
        @(negedge clk);
        check("sync_idle", busy, 0);
        start = 0;
        repeat (2) @(negedge clk);

        go();
        check("s1_clr", clear_accum, 1);
        @(negedge clk);
        check("s1_clr_pulse", clear_accum, 0);
        run_win(18'h10000, 18'h08000, 0, "s1");
        check("s1_ref", ref_level, 'h10000);
        check("s1_pow", err_power, 'h02000);
        check("s1_cnt", err_count, 0);
        @(negedge clk);
        check("s1_busy", busy, 0);
        check("s1_done_len", done, 0);
        check("s1_nclr", n_clr, 1);

        start = 1;
        @(negedge clk);
        start = 0;
        sym_clk_en = 1;
        @(negedge clk);
        sym_clk_en = 0;
        sym(18'h0, 18'h0, 1);
        sym(18'h0, 18'h0, 1);
        sym(18'h10000, 18'h0, 1);
        sym(18'h30000, 18'h0, 0);
        sym(18'h10000, 18'h0, 1);
        check("s2_early_done", done, 0);
        sym(18'h20000, 18'h20000, 0);
        check("s2_done", done, 1);
        check("s2_ref", ref_level, (3 * 'h10000 + 131071) >> 2);
        check("s2_pow", err_power, 'h08000);
        check("s2_cnt", err_count, 2);
        @(negedge clk);
        check("s2_busy", busy, 0);

        cont = 1;
        go();
        run_win(18'h08000, 18'h10000, 1, "s3a");
        check("s3_ref", ref_level, 'h08000);
        check("s3_pow", err_power, 'h08000);
        check("s3_cnt", err_count, 4);
        @(negedge clk);
        check("s3_reclr", clear_accum, 1);
        check("s3_busy", busy, 1);
        cont = 0;
        run_win(18'h08000, 18'h10000, 1, "s3b");
        @(negedge clk);
        check("s3_idle", busy, 0);
        check("s3_noclr", clear_accum, 0);
        check("s3_ndone", n_done, 4);

        go();
        repeat (2) sym(18'h10000, 18'h0, 0);
        repeat (2) sym(18'h3FFFF, 18'h3FFFF, 1);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("s4_busy", busy, 0);
        repeat (4) sym(18'h10000, 18'h0, 0);
        check("s4_still_idle", busy, 0);
        check("s4_ndone", n_done, 4);
        check("s4_ref", ref_level, 'h08000);
        check("s4_pow", err_power, 'h08000);
        check("s4_cnt", err_count, 4);

        clr0 = n_clr;
        start = 1;
        abort = 1;
        @(negedge clk);
        start = 0;
        abort = 0;
        check("s5_noclr", clear_accum, 0);
        check("s5_busy", busy, 0);
        @(negedge clk);
        check("s5_nclr", n_clr, clr0);
        go();
        repeat (3) sym(18'h10000, 18'h08000, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) sym(18'h10000, 18'h08000, 0);
        check("s5_early_done", done, 0);
        sym(18'h10000, 18'h08000, 0);
        check("s5_done", done, 1);
        check("s5_ref", ref_level, 'h10000);
        check("s5_pow", err_power, 'h02000);
        check("s5_cnt", err_count, 0);
        @(negedge clk);
        check("s5_nclr2", n_clr, clr0 + 1);

        go();
        sym(18'h10000, 18'h08000, 0);
        #2 reset = 0;
        #1;
        check("s6_busy", busy, 0);
        check("s6_clr", clear_accum, 0);
        check("s6_done", done, 0);
        check("s6_ref", ref_level, 0);
        check("s6_pow", err_power, 0);
        check("s6_cnt", err_count, 0);
        @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        check("s6_idle", busy, 0);
        go();
        run_win(18'h10000, 18'h08000, 0, "s6");
        check("s6_ref2", ref_level, 'h10000);
        check("s6_pow2", err_power, 'h02000);
        check("s6_cnt2", err_count, 0);
        repeat (2) @(negedge clk);
        check("final_ndone", n_done, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
